// File: rtl/pytxaclbufctrl_if.sv
// Signal bundle between the ACL TX ping-pong buffer and its two clients:
// the baseband state machine (host writer) and the link controller (air reader).
interface pytxaclbufctrl_if;
  logic [7:0]  bsm_addr;
  logic [31:0] bsm_din;
  logic        bsm_cs;
  logic        bsm_we;
  logic        bsm_commit_p;
  logic [9:0]  bsm_pylenByte;
  logic [7:0]  lnctrl_addr;
  logic        lnctrl_cs;
  logic        lnctrl_txstart_p;
  logic        ms_tslot_p;
  logic        pk_encode;
  logic        dec_hecgood;
  logic        dec_arqn;
  logic        regi_aclflush;
  logic [31:0] lnctrl_dout;
  logic [9:0]  lnctrl_txlenByte;
  logic [7:0]  lnctrl_endaddr;
  logic        lnctrl_txvalid;
  logic        lnctrl_seqn;
  logic        regi_acltxbuffull;

  modport slave (
    input  bsm_addr, bsm_din, bsm_cs, bsm_we, bsm_commit_p, bsm_pylenByte,
    input  lnctrl_addr, lnctrl_cs, lnctrl_txstart_p,
    input  ms_tslot_p, pk_encode, dec_hecgood, dec_arqn, regi_aclflush,
    output lnctrl_dout, lnctrl_txlenByte, lnctrl_endaddr, lnctrl_txvalid,
    output lnctrl_seqn, regi_acltxbuffull
  );

  modport master (
    output bsm_addr, bsm_din, bsm_cs, bsm_we, bsm_commit_p, bsm_pylenByte,
    output lnctrl_addr, lnctrl_cs, lnctrl_txstart_p,
    output ms_tslot_p, pk_encode, dec_hecgood, dec_arqn, regi_aclflush,
    input  lnctrl_dout, lnctrl_txlenByte, lnctrl_endaddr, lnctrl_txvalid,
    input  lnctrl_seqn, regi_acltxbuffull
  );
endinterface

// File: rtl/pytxaclbufctrl.sv
// Ping-pong ACL TX payload buffer: host fills one 256x32 bank while the link
// controller sends (and resends) the other; a bank is freed only on a valid ACK.

module sram256x32_1p (
  input  logic        clk,
  input  logic        cs,
  input  logic        we,
  input  logic [7:0]  addr,
  input  logic [31:0] din,
  output logic [31:0] dout
);
  logic [31:0] mem [256];

  // Single port: a write cycle leaves the previous read data on dout.
  always_ff @(posedge clk) begin
    if (cs) begin
      if (we) mem[addr] <= din;
      else    dout      <= mem[addr];
    end
  end
endmodule

module pytxaclbufctrl (
  input  logic             clk_6M,
  input  logic             rst,
  pytxaclbufctrl_if.slave  bus
);
  logic       hw, lr, sent, seqn;
  logic [1:0] full;
  logic [9:0] len0, len1;

  logic       hw_n, lr_n, sent_n, seqn_n;
  logic [1:0] full_n;
  logic [9:0] len0_n, len1_n;

  logic        commit, rx_slot, ack;
  logic [31:0] bank_dout [2];
  logic [9:0]  len_lr;

  assign commit  = bus.bsm_commit_p && !full[hw];
  assign rx_slot = bus.ms_tslot_p && !bus.pk_encode;
  // sent gates the ACK so a duplicate ACK cannot release a bank twice
  assign ack     = rx_slot && bus.dec_hecgood && bus.dec_arqn && sent;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    localparam logic ID = 1'(b);
    logic        host_own;
    logic        cs, we;
    logic [7:0]  addr;
    logic [31:0] din;

    assign host_own = (hw == ID) && !full[b];
    assign cs   = host_own ? bus.bsm_cs : bus.lnctrl_cs;
    assign we   = host_own && bus.bsm_cs && bus.bsm_we;
    assign addr = host_own ? bus.bsm_addr : bus.lnctrl_addr;
    assign din  = host_own ? bus.bsm_din : 32'd0;

    sram256x32_1p u_sram (
      .clk  (clk_6M),
      .cs   (cs),
      .we   (we),
      .addr (addr),
      .din  (din),
      .dout (bank_dout[b])
    );
  end

  always_comb begin
    hw_n   = hw;
    lr_n   = lr;
    full_n = full;
    sent_n = sent;
    seqn_n = seqn;
    len0_n = len0;
    len1_n = len1;
    if (bus.regi_aclflush) begin
      full_n = 2'b00;
      hw_n   = 1'b0;
      lr_n   = 1'b0;
      sent_n = 1'b0;
    end else begin
      // ACK and commit never target the same bank, so both apply.
      if (ack) begin
        full_n[lr] = 1'b0;
        lr_n       = ~lr;
        seqn_n     = ~seqn;
      end
      if (commit) begin
        full_n[hw] = 1'b1;
        hw_n       = ~hw;
        if (hw) len1_n = bus.bsm_pylenByte;
        else    len0_n = bus.bsm_pylenByte;
      end
      if (rx_slot)
        sent_n = 1'b0;
      else if (bus.lnctrl_txstart_p && full[lr])
        sent_n = 1'b1;
    end
  end

  always_ff @(posedge clk_6M or posedge rst) begin
    if (rst) begin
      hw   <= 1'b0;
      lr   <= 1'b0;
      full <= 2'b00;
      sent <= 1'b0;
      seqn <= 1'b0;
      len0 <= 10'd0;
      len1 <= 10'd0;
    end else begin
      hw   <= hw_n;
      lr   <= lr_n;
      full <= full_n;
      sent <= sent_n;
      seqn <= seqn_n;
      len0 <= len0_n;
      len1 <= len1_n;
    end
  end

  assign len_lr = lr ? len1 : len0;

  assign bus.lnctrl_dout       = lr ? bank_dout[1] : bank_dout[0];
  assign bus.lnctrl_txlenByte  = len_lr;
  // ceil(len/4)-1 equals floor((len-1)/4) for len>0
  assign bus.lnctrl_endaddr    = (len_lr == 10'd0) ? 8'd0 : 8'((len_lr - 10'd1) >> 2);
  assign bus.lnctrl_txvalid    = full[lr];
  assign bus.lnctrl_seqn       = seqn;
  assign bus.regi_acltxbuffull = full[hw];
endmodule

// File: tb/tb_pytxaclbufctrl.sv
// Self-checking bench for pytxaclbufctrl: directed ping-pong/ARQ scenarios plus
// randomized traffic compared every cycle against a queue-based packet model.
module tb_pytxaclbufctrl;
  logic clk_6M = 1'b0;
  logic rst    = 1'b1;
  bit   check_en = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  pytxaclbufctrl_if bus ();

  pytxaclbufctrl dut (
    .clk_6M (clk_6M),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 clk_6M = ~clk_6M;

  // Model: a FIFO of committed bank indices (head = bank on air) plus host bank.
  bit          m_q [$];
  bit          m_hw, m_sent, m_seqn;
  logic [9:0]  m_len [2];
  logic [31:0] m_mem [2][256];
  bit          m_wr  [2][256];
  bit          pend_v, pend_bank, pend_known;
  logic [31:0] pend_data;
  bit          mdl_lr, mdl_ack, mdl_rx;
  int          mdl_sz;

  function automatic bit cur_lr();
    return (m_q.size() > 0) ? m_q[0] : m_hw;
  endfunction

  function automatic int exp_end(int len);
    if (len == 0) return 0;
    return ((len + 3) / 4 - 1) % 256;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk_6M or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_hw = 0; m_sent = 0; m_seqn = 0;
      m_len[0] = '0; m_len[1] = '0;
      pend_v = 0;
    end else begin
      mdl_sz = m_q.size();
      mdl_lr = cur_lr();
      pend_v = 0;
      if (bus.lnctrl_cs && mdl_sz > 0) begin
        pend_v     = 1;
        pend_bank  = mdl_lr;
        pend_known = m_wr[mdl_lr][bus.lnctrl_addr];
        pend_data  = m_mem[mdl_lr][bus.lnctrl_addr];
      end
      if (bus.bsm_cs && bus.bsm_we && mdl_sz < 2) begin
        m_mem[m_hw][bus.bsm_addr] = bus.bsm_din;
        m_wr[m_hw][bus.bsm_addr]  = 1;
      end
      if (bus.regi_aclflush) begin
        m_q.delete();
        m_hw = 0; m_sent = 0;
      end else begin
        mdl_rx  = bus.ms_tslot_p && !bus.pk_encode;
        mdl_ack = mdl_rx && bus.dec_hecgood && bus.dec_arqn && m_sent;
        if (mdl_ack) begin
          void'(m_q.pop_front());
          m_seqn = !m_seqn;
        end
        if (bus.bsm_commit_p && mdl_sz < 2) begin
          m_len[m_hw] = bus.bsm_pylenByte;
          m_q.push_back(m_hw);
          m_hw = !m_hw;
        end
        if (mdl_rx) m_sent = 0;
        else if (bus.lnctrl_txstart_p && mdl_sz > 0) m_sent = 1;
      end
    end
  end

  always @(negedge clk_6M) begin
    if (!rst && check_en) begin
      checkOutput("txvalid", 32'(bus.lnctrl_txvalid), 32'(m_q.size() > 0));
      checkOutput("buffull", 32'(bus.regi_acltxbuffull), 32'(m_q.size() == 2));
      checkOutput("txlen", 32'(bus.lnctrl_txlenByte), 32'(m_len[cur_lr()]));
      checkOutput("endaddr", 32'(bus.lnctrl_endaddr), 32'(exp_end(int'(m_len[cur_lr()]))));
      checkOutput("seqn", 32'(bus.lnctrl_seqn), 32'(m_seqn));
      if (pend_v && pend_known && pend_bank == cur_lr())
        checkOutput("dout", bus.lnctrl_dout, pend_data);
    end
  end

  task automatic idle();
    bus.bsm_addr = '0; bus.bsm_din = '0; bus.bsm_cs = 0; bus.bsm_we = 0;
    bus.bsm_commit_p = 0; bus.bsm_pylenByte = '0;
    bus.lnctrl_addr = '0; bus.lnctrl_cs = 0; bus.lnctrl_txstart_p = 0;
    bus.ms_tslot_p = 0; bus.pk_encode = 0; bus.dec_hecgood = 0; bus.dec_arqn = 0;
    bus.regi_aclflush = 0;
  endtask

  task automatic hostWrite(input logic [7:0] a, input logic [31:0] d);
    bus.bsm_cs = 1; bus.bsm_we = 1; bus.bsm_addr = a; bus.bsm_din = d;
    @(negedge clk_6M);
    bus.bsm_cs = 0; bus.bsm_we = 0;
  endtask

  task automatic commitBank(input logic [9:0] len);
    bus.bsm_commit_p = 1; bus.bsm_pylenByte = len;
    @(negedge clk_6M);
    bus.bsm_commit_p = 0;
  endtask

  task automatic lnRead(input logic [7:0] a);
    bus.lnctrl_cs = 1; bus.lnctrl_addr = a;
    @(negedge clk_6M);
    bus.lnctrl_cs = 0;
  endtask

  task automatic txStart();
    bus.lnctrl_txstart_p = 1;
    @(negedge clk_6M);
    bus.lnctrl_txstart_p = 0;
  endtask

  task automatic rxSlot(input bit hec, input bit arqn);
    bus.ms_tslot_p = 1; bus.pk_encode = 0; bus.dec_hecgood = hec; bus.dec_arqn = arqn;
    @(negedge clk_6M);
    bus.ms_tslot_p = 0; bus.dec_hecgood = 0; bus.dec_arqn = 0;
  endtask

  task automatic flushBanks();
    bus.regi_aclflush = 1;
    @(negedge clk_6M);
    bus.regi_aclflush = 0;
  endtask

  task automatic applyStimulus();
    bus.bsm_cs           = ($urandom_range(1) == 1);
    bus.bsm_we           = ($urandom_range(1) == 1);
    bus.bsm_addr         = 8'($urandom_range(7));
    bus.bsm_din          = $urandom;
    bus.bsm_commit_p     = ($urandom_range(7) == 0);
    bus.bsm_pylenByte    = 10'($urandom_range(1023));
    bus.lnctrl_cs        = ($urandom_range(1) == 1);
    bus.lnctrl_addr      = 8'($urandom_range(7));
    bus.lnctrl_txstart_p = ($urandom_range(5) == 0);
    bus.ms_tslot_p       = ($urandom_range(4) == 0);
    bus.pk_encode        = ($urandom_range(1) == 1);
    bus.dec_hecgood      = ($urandom_range(4) != 0);
    bus.dec_arqn         = ($urandom_range(4) < 3);
    bus.regi_aclflush    = ($urandom_range(63) == 0);
    @(negedge clk_6M);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_txvalid"}, 32'(bus.lnctrl_txvalid), 32'd0);
    checkOutput({tag, "_buffull"}, 32'(bus.regi_acltxbuffull), 32'd0);
    checkOutput({tag, "_txlen"}, 32'(bus.lnctrl_txlenByte), 32'd0);
    checkOutput({tag, "_endaddr"}, 32'(bus.lnctrl_endaddr), 32'd0);
    checkOutput({tag, "_seqn"}, 32'(bus.lnctrl_seqn), 32'd0);
  endtask

  initial begin
    idle();
    repeat (2) @(negedge clk_6M);
    checkResetOutputs("rst");
    rst = 0;
    check_en = 1;

    for (int i = 0; i < 8; i++) hostWrite(8'(i), 32'h11223344 + 32'(i));
    commitBank(10'd30);
    checkOutput("c1_txvalid", 32'(bus.lnctrl_txvalid), 32'd1);
    checkOutput("c1_txlen", 32'(bus.lnctrl_txlenByte), 32'd30);
    checkOutput("c1_endaddr", 32'(bus.lnctrl_endaddr), 32'd7);
    checkOutput("c1_buffull", 32'(bus.regi_acltxbuffull), 32'd0);
    for (int i = 0; i < 8; i++) begin
      lnRead(8'(i));
      checkOutput("c1_read", bus.lnctrl_dout, 32'h11223344 + 32'(i));
    end

    hostWrite(8'd0, 32'hA5A50000);
    commitBank(10'd1023);
    checkOutput("c2_buffull", 32'(bus.regi_acltxbuffull), 32'd1);
    checkOutput("c2_endaddr", 32'(bus.lnctrl_endaddr), 32'd7);
    hostWrite(8'd0, 32'hDEADBEEF);
    lnRead(8'd0);
    checkOutput("blocked_write", bus.lnctrl_dout, 32'h11223344);

    txStart();
    rxSlot(1'b1, 1'b0);
    checkOutput("nak_txlen", 32'(bus.lnctrl_txlenByte), 32'd30);
    checkOutput("nak_seqn", 32'(bus.lnctrl_seqn), 32'd0);
    rxSlot(1'b1, 1'b1);
    checkOutput("dupack_txlen", 32'(bus.lnctrl_txlenByte), 32'd30);
    checkOutput("dupack_buffull", 32'(bus.regi_acltxbuffull), 32'd1);
    txStart();
    rxSlot(1'b1, 1'b1);
    checkOutput("ack_txvalid", 32'(bus.lnctrl_txvalid), 32'd1);
    checkOutput("ack_txlen", 32'(bus.lnctrl_txlenByte), 32'd1023);
    checkOutput("ack_endaddr", 32'(bus.lnctrl_endaddr), 32'd255);
    checkOutput("ack_seqn", 32'(bus.lnctrl_seqn), 32'd1);
    checkOutput("ack_buffull", 32'(bus.regi_acltxbuffull), 32'd0);
    lnRead(8'd0);
    checkOutput("bank1_read", bus.lnctrl_dout, 32'hA5A50000);

    txStart();
    bus.bsm_commit_p = 1; bus.bsm_pylenByte = 10'd0;
    bus.ms_tslot_p = 1; bus.pk_encode = 0; bus.dec_hecgood = 1; bus.dec_arqn = 1;
    @(negedge clk_6M);
    idle();
    checkOutput("both_txvalid", 32'(bus.lnctrl_txvalid), 32'd1);
    checkOutput("both_txlen", 32'(bus.lnctrl_txlenByte), 32'd0);
    checkOutput("both_endaddr", 32'(bus.lnctrl_endaddr), 32'd0);
    checkOutput("both_seqn", 32'(bus.lnctrl_seqn), 32'd0);
    checkOutput("both_buffull", 32'(bus.regi_acltxbuffull), 32'd0);

    commitBank(10'd5);
    checkOutput("full2_buffull", 32'(bus.regi_acltxbuffull), 32'd1);
    flushBanks();
    checkOutput("flush_txvalid", 32'(bus.lnctrl_txvalid), 32'd0);
    checkOutput("flush_buffull", 32'(bus.regi_acltxbuffull), 32'd0);
    checkOutput("flush_txlen", 32'(bus.lnctrl_txlenByte), 32'd0);

    repeat (3000) applyStimulus();
    idle();

    flushBanks();
    hostWrite(8'd3, 32'h01020304);
    commitBank(10'd44);
    checkOutput("pre_rst_txvalid", 32'(bus.lnctrl_txvalid), 32'd1);
    bus.bsm_cs = 1; bus.bsm_we = 1; bus.bsm_addr = 8'd4; bus.bsm_din = 32'h55AA55AA;
    @(posedge clk_6M);
    #2 rst = 1;
    #1 checkResetOutputs("async_rst");
    idle();
    @(negedge clk_6M);
    rst = 0;
    repeat (3) @(negedge clk_6M);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
